// File: rtl/uart_frame_ctrl.sv
// Receives A5-prefixed, length-delimited, checksummed frames from a UART byte stream.
// It holds one verified frame for random-access readout until the consumer acknowledges it.
module uart_frame_ctrl #(
  parameter int CLK_HZ       = 12_000_000,
  parameter int TIMEOUT_CLKS = 12_000,
  parameter int MAX_LEN      = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RX_VALID,
  input  logic [7:0] RX_DATA,
  input  logic [2:0] RD_ADDR,
  input  logic       FRAME_ACK,
  output logic       FRAME_READY,
  output logic [3:0] FRAME_LEN,
  output logic [7:0] RD_DATA,
  output logic       BUSY,
  output logic       ERR_CSUM,
  output logic       ERR_LEN,
  output logic       ERR_TIMEOUT,
  output logic       ERR_OVERRUN
);

  localparam int            TW        = $clog2(TIMEOUT_CLKS);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CLKS - 1);
  localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [7:0]    SOF       = 8'hA5;

  if (CLK_HZ < 1 || TIMEOUT_CLKS < 2 || MAX_LEN < 1 || MAX_LEN > 8) begin : g_param_check
    $error("uart_frame_ctrl: parameter out of range");
  end

  typedef enum logic [2:0] {S_IDLE, S_LEN, S_PAYLOAD, S_CSUM, S_DONE} state_e;

  state_e        state_q, state_d;
  logic          rx_valid_q;
  logic [3:0]    len_q, len_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    csum_q, csum_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [3:0]    frame_len_q, frame_len_d;
  logic          frame_ready_q, frame_ready_d;
  logic          busy_q, busy_d;
  logic          err_csum_q, err_csum_d;
  logic          err_len_q, err_len_d;
  logic          err_timeout_q, err_timeout_d;
  logic          err_overrun_q, err_overrun_d;
  logic          buf_we;
  logic [7:0]    buf_q [0:7];
  logic          strobe;

  // One strobe per RX_VALID high period, however long the receiver holds it.
  assign strobe = RX_VALID & ~rx_valid_q;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves one unassigned and infers a latch.
    state_d       = state_q;
    len_d         = len_q;
    idx_d         = idx_q;
    csum_d        = csum_q;
    tmo_d         = tmo_q;
    frame_len_d   = frame_len_q;
    err_csum_d    = 1'b0;
    err_len_d     = 1'b0;
    err_timeout_d = 1'b0;
    err_overrun_d = 1'b0;
    buf_we        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (strobe && RX_DATA == SOF) begin
          state_d = S_LEN;
          tmo_d   = '0;
        end
      end
      S_LEN, S_PAYLOAD, S_CSUM: begin
        if (strobe) begin
          tmo_d = '0;
          case (state_q)
            S_LEN: begin
              if (RX_DATA != 8'd0 && RX_DATA <= MAX_LEN_B) begin
                len_d   = RX_DATA[3:0];
                csum_d  = RX_DATA;
                idx_d   = 3'd0;
                state_d = S_PAYLOAD;
              end else begin
                err_len_d = 1'b1;
                state_d   = S_IDLE;
              end
            end
            S_PAYLOAD: begin
              buf_we = 1'b1;
              csum_d = csum_q + RX_DATA;
              idx_d  = idx_q + 3'd1;
              if ({1'b0, idx_q} == len_q - 4'd1) state_d = S_CSUM;
            end
            default: begin
              if (RX_DATA == csum_q) begin
                frame_len_d = len_q;
                state_d     = S_DONE;
              end else begin
                err_csum_d = 1'b1;
                state_d    = S_IDLE;
              end
            end
          endcase
        end else if (tmo_q == TMO_LAST) begin
          err_timeout_d = 1'b1;
          tmo_d         = '0;
          state_d       = S_IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_DONE: begin
        if (strobe) err_overrun_d = 1'b1;
        if (FRAME_ACK) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Status outputs are registered from the next state so they line up with it.
    frame_ready_d = (state_d == S_DONE);
    busy_d        = (state_d == S_LEN) || (state_d == S_PAYLOAD) || (state_d == S_CSUM);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q       <= S_IDLE;
      rx_valid_q    <= 1'b1;
      len_q         <= 4'd0;
      idx_q         <= 3'd0;
      csum_q        <= 8'd0;
      tmo_q         <= '0;
      frame_len_q   <= 4'd0;
      frame_ready_q <= 1'b0;
      busy_q        <= 1'b0;
      err_csum_q    <= 1'b0;
      err_len_q     <= 1'b0;
      err_timeout_q <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rx_valid_q    <= RX_VALID;
      len_q         <= len_d;
      idx_q         <= idx_d;
      csum_q        <= csum_d;
      tmo_q         <= tmo_d;
      frame_len_q   <= frame_len_d;
      frame_ready_q <= frame_ready_d;
      busy_q        <= busy_d;
      err_csum_q    <= err_csum_d;
      err_len_q     <= err_len_d;
      err_timeout_q <= err_timeout_d;
      err_overrun_q <= err_overrun_d;
    end
  end

  // NOTE: the payload buffer has no reset; a stale byte is never exposed as valid because FRAME_READY gates it.
  always_ff @(posedge CLK) begin
    if (buf_we) buf_q[idx_q] <= RX_DATA;
  end

  assign RD_DATA     = buf_q[RD_ADDR];
  assign FRAME_READY = frame_ready_q;
  assign FRAME_LEN   = frame_len_q;
  assign BUSY        = busy_q;
  assign ERR_CSUM    = err_csum_q;
  assign ERR_LEN     = err_len_q;
  assign ERR_TIMEOUT = err_timeout_q;
  assign ERR_OVERRUN = err_overrun_q;

endmodule

// File: doc/uart_frame_ctrl.md
UART_FRAME_CTRL -- requirements
Module: uart_frame_ctrl

Interface
REQ-001 SHALL provide parameter CLK_HZ, default 12_000_000, system clock frequency in Hz.
REQ-002 SHALL provide parameter TIMEOUT_CLKS, default 12_000, inter-byte timeout in CLK cycles (1 ms at 12 MHz).
REQ-003 SHALL provide parameter MAX_LEN, default 8, maximum payload bytes per frame (range 1..8).
REQ-004 SHALL have port CLK  input  1  single system clock, all state updated on rising edge.
REQ-005 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port RX_VALID  input  1  byte-valid level from UART receiver; may stay high for several cycles per byte.
REQ-007 SHALL have port RX_DATA  input  8  received byte, stable while RX_VALID high.
REQ-008 SHALL have port RD_ADDR  input  3  payload read index.
REQ-009 SHALL have port FRAME_ACK  input  1  consumer releases the held frame.
REQ-010 SHALL have port FRAME_READY  output  1  complete, checksum-verified frame held.
REQ-011 SHALL have port FRAME_LEN  output  4  payload length of the held frame.
REQ-012 SHALL have port RD_DATA  output  8  payload byte at RD_ADDR, combinational from buffer.
REQ-013 SHALL have port BUSY  output  1  high in states LEN, PAYLOAD, CSUM.
REQ-014 SHALL have ports ERR_CSUM, ERR_LEN, ERR_TIMEOUT, ERR_OVERRUN  output  1 each  single-cycle error pulses.

Function
REQ-015 SHALL register RX_VALID into rx_valid_d; byte strobe = RX_VALID & ~rx_valid_d; exactly one strobe per RX_VALID high period.
REQ-016 SHALL implement states IDLE, LEN, PAYLOAD, CSUM, DONE; all transitions on a strobe unless stated otherwise.
REQ-017 IDLE: strobe with RX_DATA = 0xA5 -> LEN; any other byte discarded, no error.
REQ-018 LEN: RX_DATA in 1..MAX_LEN -> store length, csum <= RX_DATA, idx <= 0, -> PAYLOAD; 0 or > MAX_LEN -> ERR_LEN pulse, -> IDLE.
REQ-019 PAYLOAD: buffer[idx] <= RX_DATA, csum <= (csum + RX_DATA) mod 256, idx++; on byte idx = len-1 -> CSUM.
REQ-020 CSUM: RX_DATA = csum -> DONE, FRAME_READY = 1 and FRAME_LEN = length from next cycle; mismatch -> ERR_CSUM pulse, -> IDLE.
REQ-021 DONE: buffer and FRAME_LEN frozen; FRAME_ACK -> IDLE, FRAME_READY low the following cycle.
REQ-022 DONE: strobe without ACK -> byte dropped, ERR_OVERRUN pulse, remain DONE.
REQ-023 DONE: strobe and FRAME_ACK same cycle -> byte dropped, ERR_OVERRUN pulse, -> IDLE.
REQ-024 FRAME_ACK outside DONE SHALL be ignored.
REQ-025 Timeout counter SHALL clear on every strobe and on entry to LEN, and increment every cycle in LEN/PAYLOAD/CSUM; reaching TIMEOUT_CLKS-1 -> ERR_TIMEOUT pulse, -> IDLE.
REQ-026 Strobe and timeout in the same cycle: strobe wins, counter clears, no error.
REQ-027 RD_DATA SHALL equal buffer[RD_ADDR]; RD_ADDR >= FRAME_LEN returns stale data, no error.
REQ-028 Error pulses SHALL be registered, one cycle wide, asserted the cycle after the causing strobe or timeout.

Reset
REQ-029 RST high SHALL asynchronously force state IDLE, idx 0, csum 0, timeout counter 0, FRAME_LEN 0, FRAME_READY, BUSY, all ERR_* to 0.
REQ-030 rx_valid_d SHALL reset to 1 so RX_VALID held high across reset release yields no strobe.
REQ-031 Reset mid-frame SHALL discard the partial frame; buffer contents need not be cleared.

Verification
REQ-032 Bytes A5 03 11 22 33 69 -> FRAME_READY=1, FRAME_LEN=3, RD_ADDR 0/1/2 -> 11/22/33; FRAME_ACK -> FRAME_READY=0 next cycle.
REQ-033 Bytes A5 03 11 22 33 68 -> ERR_CSUM one-cycle pulse, FRAME_READY stays 0; following correct frame accepted.
REQ-034 Bytes 00 FF A5 09 -> noise ignored, ERR_LEN pulse, BUSY=0; RX_VALID held high 100 cycles counts as one byte.
REQ-035 Bytes A5 02 then idle 12_000 cycles -> ERR_TIMEOUT pulse, BUSY=0; byte at cycle 11_998 instead -> no timeout.
REQ-036 Frame held, byte 55 sent before ACK -> ERR_OVERRUN pulse, RD_DATA and FRAME_LEN unchanged; byte with ACK same cycle -> overrun pulse, IDLE.
REQ-037 RST pulsed during PAYLOAD with RX_VALID high -> all outputs 0, no strobe after release, next A5 frame received normally.
